// File: rtl/program_loader.sv
// Host-side instruction-memory loader: byte stream in, 16-bit words out,
// trailing XOR checksum, and a CPU hold while a load is pending or bad.
module program_loader #(
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [15:0]       words_loaded
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_DATA_H,
    S_DATA_L,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state, state_nx;
  logic [15:0] count;
  logic [15:0] index;
  logic [7:0]  csum;
  logic [7:0]  hi;
  logic        acc;
  logic        restart;
  logic [15:0] n_len;

  assign acc   = rx_valid & rx_ready;
  assign n_len = {count[15:8], rx_data};
  assign restart = start & ((state == S_IDLE) |
                            (state == S_DONE) |
                            (state == S_ERR));

  // State register; reset drops mem_wren at once via the state decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nx = state;
    rx_ready = 1'b0;
    mem_wren = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    unique case (state)
      S_IDLE: begin
        cpu_hold = 1'b0;
        if (start) state_nx = S_LEN_H;
      end
      S_LEN_H: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nx = S_LEN_L;
      end
      S_LEN_L: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          if ({1'b0, n_len} > MAX_N) state_nx = S_ERR;
          else if (n_len == 16'd0)   state_nx = S_CHECK;
          else                       state_nx = S_DATA_H;
        end
      end
      S_DATA_H: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nx = S_DATA_L;
      end
      S_DATA_L: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nx = S_WRITE;
      end
      S_WRITE: begin
        mem_wren = 1'b1;
        busy     = 1'b1;
        if (index == count - 16'd1) state_nx = S_CHECK;
        else                        state_nx = S_DATA_H;
      end
      S_CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          if (rx_data == csum) state_nx = S_DONE;
          else                 state_nx = S_ERR;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nx = S_LEN_H;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_nx = S_LEN_H;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: length, word assembly, checksum, write address and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      index        <= '0;
      csum         <= '0;
      hi           <= '0;
      mem_address  <= '0;
      mem_data     <= '0;
      words_loaded <= '0;
    end else begin
      if (restart) begin
        index        <= '0;
        csum         <= '0;
        words_loaded <= '0;
      end
      if (acc && state != S_CHECK) csum <= csum ^ rx_data;
      if (acc && state == S_LEN_H) count[15:8] <= rx_data;
      if (acc && state == S_LEN_L) count[7:0] <= rx_data;
      if (acc && state == S_DATA_H) hi <= rx_data;
      if (acc && state == S_DATA_L) begin
        mem_data    <= {hi, rx_data};
        mem_address <= BASE + ADDR_W'(index);
      end
      if (state == S_WRITE) begin
        index <= index + 16'd1;
        if (words_loaded != 16'hFFFF)
          words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a stream-level model
// of the load format (length, words, XOR checksum).
module tb_program_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;
  logic [15:0] words_loaded;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int last_wr = -10;
  wq_t wr_q;

  program_loader #(
    .ADDR_W(16),
    .BASE_ADDR(0),
    .MAX_WORDS(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .mem_wren(mem_wren),
    .busy(busy),
    .done(done),
    .error(error),
    .cpu_hold(cpu_hold),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Capture every write; no byte may be taken during one and
  // writes must be at least three cycles apart.
  always @(negedge clk) begin
    if (mem_wren === 1'b1) begin
      wr_q.push_back({mem_address, mem_data});
      chk("wr_rdy", {31'd0, rx_ready}, 32'd0);
      chk("wr_gap", {31'd0, (cyc - last_wr) >= 3}, 32'd1);
      last_wr = cyc;
    end
  end

  // Expected outcome straight from the stream format.
  task automatic model(input bq_t q, output wq_t ew,
                       output bit ok, output int wl);
    int n;
    logic [7:0] x;
    ew.delete();
    n = {q[0], q[1]};
    if (n > 256) begin
      ok = 1'b0;
      wl = 0;
      return;
    end
    x = q[0] ^ q[1];
    for (int k = 0; k < n; k++) begin
      ew.push_back({16'(k), q[2+2*k], q[3+2*k]});
      x = x ^ q[2+2*k] ^ q[3+2*k];
    end
    ok = (q[2+2*n] == x);
    wl = n;
  endtask

  task automatic make(input int n, input bit bad, output bq_t q);
    logic [7:0] x;
    logic [7:0] b;
    q.delete();
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    if (n > 256) return;
    x = q[0] ^ q[1];
    for (int k = 0; k < 2 * n; k++) begin
      b = 8'($urandom);
      q.push_back(b);
      x = x ^ b;
    end
    if (bad) x = x ^ 8'($urandom_range(1, 255));
    q.push_back(x);
  endtask

  // Start pulse plus sender; the first byte is offered alongside start.
  task automatic send(input bq_t q, input int stop_wr,
                      input bit gaps, input bit poke);
    int i = 0;
    int t = 0;
    bit rdy;
    bit vld;
    while (i < q.size()) begin
      @(negedge clk);
      #1;
      if (stop_wr > 0 && wr_q.size() >= stop_wr) begin
        rx_valid = 1'b0;
        return;
      end
      if (t == 0) start = 1'b1;
      if (poke && i == 3) start = 1'b1;
      rx_data = q[i];
      vld = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      rx_valid = vld;
      rdy = rx_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (rdy && vld) i++;
      t++;
      if (t > 4000) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic run(input bq_t q, input bit gaps, input bit poke);
    wq_t ew;
    bit ok;
    int wl;
    int m;
    wr_q.delete();
    model(q, ew, ok, wl);
    send(q, 0, gaps, poke);
    repeat (3) @(negedge clk);
    #1;
    chk("wr_cnt", wr_q.size(), ew.size());
    m = (wr_q.size() < ew.size()) ? wr_q.size() : ew.size();
    for (int k = 0; k < m; k++) chk("wr", wr_q[k], ew[k]);
    chk("done", {31'd0, done}, {31'd0, ok});
    chk("error", {31'd0, error}, {31'd0, !ok});
    chk("hold", {31'd0, cpu_hold}, {31'd0, !ok});
    chk("busy", {31'd0, busy}, 32'd0);
    chk("rdy", {31'd0, rx_ready}, 32'd0);
    chk("wl", {16'd0, words_loaded}, 32'(wl));
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_wren"}, {31'd0, mem_wren}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, error}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_wl"}, {16'd0, words_loaded}, 32'd0);
    chk({tag, "_addr"}, {16'd0, mem_address}, 32'd0);
    chk({tag, "_data"}, {16'd0, mem_data}, 32'd0);
  endtask

  bq_t good, q;

  initial begin
    good = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB,
             8'hCD, 8'h00, 8'hFF, 8'hBC};
    #12;
    idle_outs("rst");
    @(negedge clk);
    rst = 1'b1;

    run(good, 1'b0, 1'b0);
    q = good;
    q[8] = 8'hBD;
    run(q, 1'b0, 1'b0);
    run(good, 1'b0, 1'b1);
    q = '{8'h00, 8'h00, 8'h00};
    run(q, 1'b0, 1'b0);
    q = '{8'h01, 8'h01};
    run(q, 1'b0, 1'b0);
    q = '{8'h00, 8'h01, 8'hAA, 8'h55, 8'hFF};
    run(q, 1'b0, 1'b0);
    q[4] = 8'hFE;
    run(q, 1'b0, 1'b0);

    wr_q.delete();
    send(good, 2, 1'b0, 1'b0);
    chk("mid_wren_pre", {31'd0, mem_wren}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    idle_outs("mid");
    @(negedge clk);
    rst = 1'b1;
    run(good, 1'b0, 1'b0);

    make(256, 1'b0, q);
    run(q, 1'b1, 1'b0);
    make(257, 1'b0, q);
    run(q, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(257, 65535)
                                       : $urandom_range(0, 6);
      make(n, $urandom_range(0, 3) == 0, q);
      run(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
